morse_tx_core: RTL and testbench

Parametrised ASCII-to-Morse transmit engine: accepts bytes through a valid/ready push port into an internal FIFO, translates each character through a fixed code table and drives a single keyed output (`morse_o`) with unit timing derived from a programmable prescaler. It is the datapath core behind the AXI4-Lite Morse peripheral. The register wrapper maps prescaler, status and FIFO-write onto its ports. Relative to the previous generation it adds parametrised depth, dash and word-gap ratios, FIFO level readout, flush, per-character done pulses and illegal-character reporting.

---
 rtl/morse_pkg.sv | 69 ++++++
 rtl/morse_tx_core_if.sv | 8 +
 rtl/morse_fifo.sv | 52 +++++
 rtl/morse_tx_core.sv | 135 +++++++++++++
 tb/tb_morse_tx_core.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: FSM states, code-table entry type and the ASCII-to-Morse lookup shared by the keyer.
package morse_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MARK, S_GAP, S_LGAP, S_WGAP} state_t;
  typedef struct packed {
    logic [2:0] len;
    logic [5:0] sym;
  } code_t;
  typedef struct packed {
    logic  valid;
    code_t code;
  } lut_t;
  localparam logic [7:0] SPACE = 8'h20;
  // Symbols are left-aligned: bit 5 is keyed first, 1 = dash.
  function automatic lut_t ascii2morse(input logic [7:0] c);
    logic [7:0] u;
    code_t      e;
    logic       v;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    e = '0;
    v = 1'b1;
    case (u)
      "A": e = {3'd2, 6'b010000};
      "B": e = {3'd4, 6'b100000};
      "C": e = {3'd4, 6'b101000};
      "D": e = {3'd3, 6'b100000};
      "E": e = {3'd1, 6'b000000};
      "F": e = {3'd4, 6'b001000};
      "G": e = {3'd3, 6'b110000};
      "H": e = {3'd4, 6'b000000};
      "I": e = {3'd2, 6'b000000};
      "J": e = {3'd4, 6'b011100};
      "K": e = {3'd3, 6'b101000};
      "L": e = {3'd4, 6'b010000};
      "M": e = {3'd2, 6'b110000};
      "N": e = {3'd2, 6'b100000};
      "O": e = {3'd3, 6'b111000};
      "P": e = {3'd4, 6'b011000};
      "Q": e = {3'd4, 6'b110100};
      "R": e = {3'd3, 6'b010000};
      "S": e = {3'd3, 6'b000000};
      "T": e = {3'd1, 6'b100000};
      "U": e = {3'd3, 6'b001000};
      "V": e = {3'd4, 6'b000100};
      "W": e = {3'd3, 6'b011000};
      "X": e = {3'd4, 6'b100100};
      "Y": e = {3'd4, 6'b101100};
      "Z": e = {3'd4, 6'b110000};
      "0": e = {3'd5, 6'b111110};
      "1": e = {3'd5, 6'b011110};
      "2": e = {3'd5, 6'b001110};
      "3": e = {3'd5, 6'b000110};
      "4": e = {3'd5, 6'b000010};
      "5": e = {3'd5, 6'b000000};
      "6": e = {3'd5, 6'b100000};
      "7": e = {3'd5, 6'b110000};
      "8": e = {3'd5, 6'b111000};
      "9": e = {3'd5, 6'b111100};
      ".": e = {3'd6, 6'b010101};
      ",": e = {3'd6, 6'b110011};
      "?": e = {3'd6, 6'b001100};
      ":": e = {3'd6, 6'b111000};
      "(": e = {3'd5, 6'b101100};
      ")": e = {3'd6, 6'b101101};
      SPACE: e = '0;
      default: v = 1'b0;
    endcase
    return {v, e};
  endfunction
endpackage

// File: rtl/morse_tx_core_if.sv
// morse_tx_core_if: valid/ready byte push port into the Morse transmit core.
interface morse_tx_core_if;
  logic       wr_valid_i;
  logic [7:0] wr_data_i;
  logic       wr_ready_o;
  modport master (output wr_valid_i, wr_data_i, input wr_ready_o);
  modport slave  (input wr_valid_i, wr_data_i, output wr_ready_o);
endinterface

// File: rtl/morse_fifo.sv
// morse_fifo: synchronous FIFO with registered level/empty/full and a synchronous flush.
module morse_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [LW-1:0] level_o,
  output logic          empty_o,
  output logic          full_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d, full_q, full_d, do_push, do_pop;
  always_comb begin
    do_push = push_i && !full_q && !flush_i;
    do_pop  = pop_i && !empty_q && !flush_i;
    wp_d    = flush_i ? '0 : wp_q + AW'(do_push);
    rp_d    = flush_i ? '0 : rp_q + AW'(do_pop);
    level_d = flush_i ? '0 : level_q + LW'(do_push) - LW'(do_pop);
    empty_d = level_d == '0;
    full_d  = level_d == LW'(DEPTH);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= data_i;
  assign data_o  = mem_q[rp_q];
  assign level_o = level_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;
endmodule

// File: rtl/morse_tx_core.sv
// morse_tx_core: ASCII-to-Morse keyer with push FIFO, unit prescaler and per-character status pulses.
module morse_tx_core
  import morse_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PRESC_W    = 32,
  parameter int DASH_LEN   = 3,
  parameter int WORD_GAP   = 7,
  localparam int LW = $clog2(FIFO_DEPTH + 1),
  localparam int UW = $clog2(WORD_GAP + 1)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [PRESC_W-1:0] prescale_i,
  morse_tx_core_if.slave     wr,
  input  logic               flush_i,
  output logic [LW-1:0]      fifo_level_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               busy_o,
  output logic               morse_o,
  output logic               char_done_o,
  output logic               bad_char_o
);
  localparam logic [UW-1:0] DASH_U = UW'(DASH_LEN - 1);
  localparam logic [UW-1:0] WGAP_U = UW'(WORD_GAP - DASH_LEN - 1);
  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [UW-1:0]      units_q, units_d;
  logic [5:0]         sym_q, sym_d;
  logic [2:0]         left_q, left_d;
  logic [7:0]         char_q, char_d, fifo_dout;
  logic               morse_q, morse_d, done_q, done_d, bad_q, bad_d, pop, push;
  lut_t               lut;
  assign push          = wr.wr_valid_i && !full_o && !flush_i;
  assign wr.wr_ready_o = !full_o && !flush_i;
  morse_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(aclk), .rst_n(aresetn), .flush_i(flush_i), .push_i(push), .data_i(wr.wr_data_i),
    .pop_i(pop), .data_o(fifo_dout), .level_o(fifo_level_o), .empty_o(empty_o), .full_o(full_o)
  );
  // presc counts clocks within a unit, units counts whole units left in the current timed state.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    units_d = units_q;
    sym_d   = sym_q;
    left_d  = left_q;
    char_d  = char_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    bad_d   = 1'b0;
    lut     = ascii2morse(char_q);
    if (flush_i) begin
      state_d = S_IDLE;
      presc_d = '0;
      units_d = '0;
    end else case (state_q)
      S_IDLE: if (!empty_o) begin
        pop     = 1'b1;
        char_d  = fifo_dout;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        presc_d = prescale_i;
        if (char_q == SPACE) begin
          state_d = S_WGAP;
          units_d = WGAP_U;
        end else if (!lut.valid) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          bad_d   = 1'b1;
        end else begin
          state_d = S_MARK;
          sym_d   = lut.code.sym;
          left_d  = lut.code.len - 3'd1;
          units_d = lut.code.sym[5] ? DASH_U : '0;
        end
      end
      default: if (presc_q != '0) presc_d = presc_q - PRESC_W'(1);
      else if (units_q != '0) begin
        units_d = units_q - UW'(1);
        presc_d = prescale_i;
      end else begin
        presc_d = prescale_i;
        case (state_q)
          S_MARK: if (left_q != '0) begin
            state_d = S_GAP;
            units_d = '0;
            sym_d   = sym_q << 1;
            left_d  = left_q - 3'd1;
          end else begin
            state_d = S_LGAP;
            units_d = DASH_U;
          end
          S_GAP: begin
            state_d = S_MARK;
            units_d = sym_q[5] ? DASH_U : '0;
          end
          default: begin
            state_d = S_IDLE;
            presc_d = '0;
            done_d  = 1'b1;
          end
        endcase
      end
    endcase
    morse_d = state_d == S_MARK;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      units_q <= '0;
      sym_q   <= '0;
      left_q  <= '0;
      char_q  <= '0;
      morse_q <= 1'b0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      units_q <= units_d;
      sym_q   <= sym_d;
      left_q  <= left_d;
      char_q  <= char_d;
      morse_q <= morse_d;
      done_q  <= done_d;
      bad_q   <= bad_d;
    end
  assign busy_o      = state_q != S_IDLE;
  assign morse_o     = morse_q;
  assign char_done_o = done_q;
  assign bad_char_o  = bad_q;
endmodule

// File: tb/tb_morse_tx_core.sv
// tb_morse_tx_core: directed self-checking bench for the Morse transmit core.
module tb_morse_tx_core;
  localparam logic [11:0] RST_VEC = 12'b0110_0000_0000;
  logic        clk = 1'b0, aresetn = 1'b0, flush = 1'b0;
  logic [31:0] prescale = '0;
  logic [4:0]  level;
  logic        empty, full, busy, morse, done, bad;
  int          compared = 0, mismatched = 0;
  int          highs[$], lows[$];
  int          dones, bads, tail;
  morse_tx_core_if ifc();
  morse_tx_core #(.FIFO_DEPTH(16), .PRESC_W(32), .DASH_LEN(3), .WORD_GAP(7)) dut (
    .aclk(clk), .aresetn(aresetn), .prescale_i(prescale), .wr(ifc), .flush_i(flush),
    .fifo_level_o(level), .empty_o(empty), .full_o(full), .busy_o(busy), .morse_o(morse),
    .char_done_o(done), .bad_char_o(bad)
  );
  wire [11:0] outs = {morse, ifc.wr_ready_o, empty, full, level, busy, done, bad};
  always #5 clk = ~clk;

  task automatic push(input logic [7:0] b);
    int n = 0;
    ifc.wr_valid_i = 1'b1;
    ifc.wr_data_i  = b;
    while (!ifc.wr_ready_o && n < 10000) begin @(negedge clk); n++; end
    @(negedge clk);
    ifc.wr_valid_i = 1'b0;
    compared++;
    if (n >= 10000) begin mismatched++; $display("FAIL push_timeout: waited %0d cycles, required < 10000", n); end
  endtask

  task automatic capture(input int ndone, input int budget);
    int   run = 0, cyc = 0;
    logic prev = 1'b0, seen = 1'b0;
    highs.delete(); lows.delete();
    dones = 0; bads = 0;
    while (dones < ndone && cyc < budget) begin
      @(negedge clk); cyc++;
      if (done) dones++;
      if (bad) bads++;
      if (morse !== prev) begin
        if (prev) highs.push_back(run);
        else if (seen) lows.push_back(run);
        if (morse) seen = 1'b1;
        prev = morse; run = 1;
      end else run++;
    end
    tail = prev ? -1 : run - 1;
  endtask

  task automatic test_reset();
    ifc.wr_valid_i = 1'b0; ifc.wr_data_i = '0; aresetn = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (outs !== RST_VEC) begin mismatched++; $display("FAIL reset_hold: got %b required %b", outs, RST_VEC); end
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (outs !== RST_VEC) begin mismatched++; $display("FAIL reset_release: got %b required %b", outs, RST_VEC); end
  endtask

  task automatic test_e_t();
    prescale = 0;
    push("E");
    compared++;
    if (empty !== 1'b0 || level !== 5'd1 || busy !== 1'b0) begin
      mismatched++; $display("FAIL e_after_push: empty=%b level=%0d busy=%b required 0 1 0", empty, level, busy);
    end
    @(negedge clk);
    compared++;
    if (busy !== 1'b1 || level !== 5'd0 || morse !== 1'b0) begin
      mismatched++; $display("FAIL e_load: busy=%b level=%0d morse=%b required 1 0 0", busy, level, morse);
    end
    capture(1, 100);
    compared++;
    if (highs.size() != 1 || highs[0] != 1) begin
      mismatched++; $display("FAIL e_mark: %0d marks first=%0d required 1 mark of 1", highs.size(), highs.size() ? highs[0] : -1);
    end
    compared++;
    if (tail != 3 || dones != 1) begin mismatched++; $display("FAIL e_lgap: tail=%0d dones=%0d required 3 1", tail, dones); end
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL e_done_width: done=%b required 0", done); end
    prescale = 1;
    push("T");
    capture(1, 200);
    compared++;
    if (highs.size() != 1 || highs[0] != 6) begin
      mismatched++; $display("FAIL t_mark: %0d marks first=%0d required 1 mark of 6", highs.size(), highs.size() ? highs[0] : -1);
    end
    compared++;
    if (tail != 6) begin mismatched++; $display("FAIL t_lgap: tail=%0d required 6", tail); end
  endtask

  task automatic test_hello();
    string msg = "hello world :)";
    string pat[14] = '{"....", ".", ".-..", ".-..", "---", " ", ".--", "---", ".-.", ".-..", "-..", " ", "---...", "-.--.-"};
    int    exp_h[$], exp_l[$];
    byte   s;
    for (int i = 0; i < 14; i++) begin
      if (pat[i] == " ") continue;
      for (int j = 0; j < pat[i].len(); j++) begin
        s = pat[i][j];
        if (j > 0) exp_l.push_back(10);
        exp_h.push_back(s == 8'h2d ? 30 : 10);
      end
      if (i < 13) exp_l.push_back(pat[i+1] == " " ? 74 : 32);
    end
    prescale = 9;
    fork
      for (int k = 0; k < msg.len(); k++) push(msg[k]);
      capture(14, 5000);
    join
    compared++;
    if (highs.size() != exp_h.size() || lows.size() != exp_l.size()) begin
      mismatched++; $display("FAIL hello_counts: marks=%0d gaps=%0d required %0d %0d", highs.size(), lows.size(), exp_h.size(), exp_l.size());
    end
    for (int i = 0; i < exp_h.size(); i++) begin
      compared++;
      if (i >= highs.size() || highs[i] != exp_h[i]) begin
        mismatched++; $display("FAIL hello_mark[%0d]: got %0d required %0d", i, i < highs.size() ? highs[i] : -1, exp_h[i]);
      end
    end
    for (int i = 0; i < exp_l.size(); i++) begin
      compared++;
      if (i >= lows.size() || lows[i] != exp_l[i]) begin
        mismatched++; $display("FAIL hello_gap[%0d]: got %0d required %0d", i, i < lows.size() ? lows[i] : -1, exp_l[i]);
      end
    end
    compared++;
    if (dones != 14 || bads != 0 || tail != 30) begin
      mismatched++; $display("FAIL hello_done: dones=%0d bads=%0d tail=%0d required 14 0 30", dones, bads, tail);
    end
  endtask

  task automatic test_full();
    int n = 0;
    prescale = 1000;
    for (int k = 0; k < 17; k++) push("E");
    compared++;
    if (level !== 5'd16 || full !== 1'b1 || ifc.wr_ready_o !== 1'b0) begin
      mismatched++; $display("FAIL full_level: level=%0d full=%b ready=%b required 16 1 0", level, full, ifc.wr_ready_o);
    end
    ifc.wr_valid_i = 1'b1; ifc.wr_data_i = "E";
    while (!ifc.wr_ready_o && n < 10000) begin @(negedge clk); n++; end
    compared++;
    if (n < 1000 || n >= 10000) begin mismatched++; $display("FAIL full_holdoff: waited %0d required 1000..9999", n); end
    compared++;
    if (level !== 5'd15) begin mismatched++; $display("FAIL full_pop_refused: level=%0d required 15", level); end
    @(negedge clk);
    ifc.wr_valid_i = 1'b0;
    compared++;
    if (level !== 5'd16 || full !== 1'b1) begin mismatched++; $display("FAIL full_refill: level=%0d full=%b required 16 1", level, full); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    compared++;
    if (level !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) begin
      mismatched++; $display("FAIL full_flush: level=%0d empty=%b busy=%b required 0 1 0", level, empty, busy);
    end
  endtask

  task automatic test_bad_char();
    prescale = 0;
    push("#");
    push("E");
    capture(2, 200);
    compared++;
    if (bads != 1 || dones != 2) begin mismatched++; $display("FAIL bad_pulses: bads=%0d dones=%0d required 1 2", bads, dones); end
    compared++;
    if (highs.size() != 1 || highs[0] != 1) begin
      mismatched++; $display("FAIL bad_keying: %0d marks first=%0d required 1 mark of 1", highs.size(), highs.size() ? highs[0] : -1);
    end
  endtask

  task automatic test_flush();
    int d = 0, h = 0;
    prescale = 9;
    for (int k = 0; k < 6; k++) push("T");
    compared++;
    if (level !== 5'd5 || morse !== 1'b1) begin mismatched++; $display("FAIL flush_setup: level=%0d morse=%b required 5 1", level, morse); end
    flush = 1'b1; ifc.wr_valid_i = 1'b1; ifc.wr_data_i = "E";
    #1;
    compared++;
    if (ifc.wr_ready_o !== 1'b0) begin mismatched++; $display("FAIL flush_ready: ready=%b required 0", ifc.wr_ready_o); end
    @(negedge clk);
    flush = 1'b0; ifc.wr_valid_i = 1'b0;
    compared++;
    if (morse !== 1'b0 || level !== 5'd0 || busy !== 1'b0 || empty !== 1'b1 || done !== 1'b0) begin
      mismatched++; $display("FAIL flush_next: morse=%b level=%0d busy=%b empty=%b done=%b required 0 0 0 1 0", morse, level, busy, empty, done);
    end
    repeat (60) begin
      @(negedge clk);
      if (done) d++;
      if (morse || level != 0) h++;
    end
    compared++;
    if (d != 0 || h != 0) begin mismatched++; $display("FAIL flush_quiet: dones=%0d active=%0d required 0 0", d, h); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    prescale = 9;
    push("T");
    while (!morse && n < 20) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    compared++;
    if (morse !== 1'b1) begin mismatched++; $display("FAIL areset_setup: morse=%b required 1", morse); end
    #2 aresetn = 1'b0;
    #1;
    compared++;
    if (outs !== RST_VEC) begin mismatched++; $display("FAIL areset_async: got %b required %b", outs, RST_VEC); end
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    prescale = 0;
    push("E");
    capture(1, 100);
    compared++;
    if (highs.size() != 1 || highs[0] != 1 || tail != 3) begin
      mismatched++; $display("FAIL areset_rekey: %0d marks first=%0d tail=%0d required 1 1 3", highs.size(), highs.size() ? highs[0] : -1, tail);
    end
  endtask

  initial begin
    test_reset();
    test_e_t();
    test_hello();
    test_full();
    test_bad_char();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
